// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and helpers for the parallel-in / serial-out
//                shift register (FSM state type, counter width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    // Two-state transmit FSM: waiting for a word, or shifting a frame out
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Width of a down-counter that must hold values 0 .. frame_len-1
    function automatic int piso_cnt_width(input int frame_len);
        return (frame_len > 2) ? $clog2(frame_len) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_register
//  Description : Parallel-in, serial-out shift register. Accepts a WIDTH-bit
//                word on a valid/ready handshake and emits it one bit per
//                clock with a qualifying valid and a last-bit marker.
//                Optional macro PISO_PARITY_EN appends an even-parity bit
//                (XOR of the data bits) after the data bits of every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_register
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             x_last_o
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int               CNT_W    = piso_cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // The shift register holds the whole frame (data plus optional parity);
    // the bit currently on the wire always sits at the output end, so x_o is
    // a plain register tap and reads 0 whenever the register is cleared.
    piso_state_e          state_q, state_d;
    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    logic [FRAME_LEN-1:0] w_frame;
    logic [FRAME_LEN-1:0] w_sr_shifted;
    logic                 w_load;

`ifdef PISO_PARITY_EN
    logic w_parity;
    assign w_parity = ^data_i;
`endif

    // Frame assembly and shift direction depend on bit order
    generate
        if (LSB_FIRST) begin : g_lsb_first
`ifdef PISO_PARITY_EN
            assign w_frame = {w_parity, data_i};
`else
            assign w_frame = data_i;
`endif
            assign w_sr_shifted = {1'b0, sr_q[FRAME_LEN-1:1]};
            assign x_o          = sr_q[0];
        end else begin : g_msb_first
`ifdef PISO_PARITY_EN
            assign w_frame = {data_i, w_parity};
`else
            assign w_frame = data_i;
`endif
            assign w_sr_shifted = {sr_q[FRAME_LEN-2:0], 1'b0};
            assign x_o          = sr_q[FRAME_LEN-1];
        end
    endgenerate

    // Ready only from registered state: idle, or presenting the final bit
    assign load_ready_o = (state_q == IDLE) || ((state_q == SHIFT) && last_q);
    assign w_load       = load_valid_i && load_ready_o;
    assign x_valid_o    = valid_q;
    assign x_last_o     = last_q;

    // Next-state logic: load a new frame, advance one bit, or fall back to idle
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    state_d = SHIFT;
                    sr_d    = w_frame;
                    cnt_d   = CNT_LOAD;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    sr_d   = w_sr_shifted;
                    cnt_d  = cnt_q - CNT_ONE;
                    last_d = (cnt_q == CNT_ONE);
                end else if (w_load) begin
                    // Back-to-back frame: no idle gap, valid stays high
                    sr_d    = w_frame;
                    cnt_d   = CNT_LOAD;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                    sr_d    = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                sr_d    = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_shift_register
//  Description : Self-checking bench for piso_shift_register. Two instances
//                (LSB-first and MSB-first) are compared every cycle against a
//                queue-of-bits model; directed scenarios add literal checks.
//                Honours PISO_PARITY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_register;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F = W + PAR;

    typedef bit bq_t[$];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lv_l = 1'b0, lv_m = 1'b0;
    logic [3:0] d_l = 4'h0, d_m = 4'h0;
    logic       rdy_l, x_l, xv_l, xl_l;
    logic       rdy_m, x_m, xv_m, xl_m;

    always #5 clk = ~clk;

    piso_shift_register #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset_n(reset_n), .load_valid_i(lv_l), .load_ready_o(rdy_l),
        .data_i(d_l), .x_o(x_l), .x_valid_o(xv_l), .x_last_o(xl_l)
    );

    piso_shift_register #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset_n(reset_n), .load_valid_i(lv_m), .load_ready_o(rdy_m),
        .data_i(d_m), .x_o(x_m), .x_valid_o(xv_m), .x_last_o(xl_m)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a queue of the bits still to appear on the wire; the head is the
    // bit shown this cycle. A word is accepted when at most one bit remains.
    function automatic bq_t model_step(input bq_t q, input logic v, input logic [3:0] d, input bit lsb);
        bit rdy;
        rdy = (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (v && rdy) begin
            for (int i = 0; i < W; i++) q.push_back(lsb ? d[i] : d[W-1-i]);
            if (PAR != 0) q.push_back(^d);
        end
        return q;
    endfunction

    bq_t q_l, q_m;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_l.delete();
            q_m.delete();
        end else begin
            q_l = model_step(q_l, lv_l, d_l, 1'b1);
            q_m = model_step(q_m, lv_m, d_m, 1'b0);
        end
    end

    // Downstream serial-in register fed by the LSB-first instance
    logic [3:0] sipo = 4'h0;
    logic       sipo_clr = 1'b0;
    always @(posedge clk) begin
        if (sipo_clr) sipo <= 4'b0101;
        else if (xv_l && !(PAR != 0 && xl_l)) sipo <= {x_l, sipo[3:1]};
    end

    // Per-cycle trace and model comparison, sampled 2 time units after the edge
    int  cyc = 0;
    bit  tx_l [4096], tv_l [4096], tl_l [4096], tr_l [4096];
    bit  tx_m [4096], tv_m [4096], tl_m [4096], tr_m [4096];
    logic [3:0] ts [4096];

    initial forever begin
        @(posedge clk);
        #2;
        check("cyc_x_l",     x_l,   (q_l.size() > 0) ? q_l[0] : 1'b0);
        check("cyc_valid_l", xv_l,  q_l.size() > 0);
        check("cyc_last_l",  xl_l,  q_l.size() == 1);
        check("cyc_ready_l", rdy_l, q_l.size() <= 1);
        check("cyc_x_m",     x_m,   (q_m.size() > 0) ? q_m[0] : 1'b0);
        check("cyc_valid_m", xv_m,  q_m.size() > 0);
        check("cyc_last_m",  xl_m,  q_m.size() == 1);
        check("cyc_ready_m", rdy_m, q_m.size() <= 1);
        if (cyc < 4096) begin
            tx_l[cyc] = x_l; tv_l[cyc] = xv_l; tl_l[cyc] = xl_l; tr_l[cyc] = rdy_l;
            tx_m[cyc] = x_m; tv_m[cyc] = xv_m; tl_m[cyc] = xl_m; tr_m[cyc] = rdy_m;
            ts[cyc] = sipo;
        end
        cyc++;
    end

    // Present a word and hold it until accepted; acc = trace index of its first bit
    task automatic load_word(input bit msb, input logic [3:0] d, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        if (msb) begin lv_m = 1'b1; d_m = d; end
        else     begin lv_l = 1'b1; d_l = d; end
        while (((msb ? rdy_m : rdy_l) == 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("load_timeout", n < 50, 1'b1);
        @(posedge clk);
        acc = cyc;
        @(negedge clk);
        if (msb) lv_m = 1'b0;
        else     lv_l = 1'b0;
    endtask

    // Literal check of a run of contiguous frames starting at trace index a
    task automatic check_frames(input string name, input bit msb, input int a, input string xs);
        int idx;
        bit last_exp;
        for (int k = 0; k < xs.len(); k++) begin
            idx = a + k;
            last_exp = ((k % F) == F - 1);
            check({name, "_x"},     msb ? tx_m[idx] : tx_l[idx], xs[k] == "1");
            check({name, "_valid"}, msb ? tv_m[idx] : tv_l[idx], 1'b1);
            check({name, "_last"},  msb ? tl_m[idx] : tl_l[idx], last_exp);
            check({name, "_ready"}, msb ? tr_m[idx] : tr_l[idx], last_exp);
        end
        check({name, "_idle_after"}, msb ? tv_m[a + xs.len()] : tv_l[a + xs.len()], 1'b0);
    endtask

    initial begin
        int a, a2, b;
        int w0, w1, w2, w3, w4;
        string e1, e2, e3, e5;
        e1 = (PAR != 0) ? "10111"      : "1011";
        e2 = (PAR != 0) ? "1000101111" : "10000111";
        e3 = (PAR != 0) ? "11011"      : "1101";
        e5 = (PAR != 0) ? "01100"      : "0110";

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_x",     x_l,   1'b0);
        check("reset_valid", xv_l,  1'b0);
        check("reset_last",  xl_l,  1'b0);
        check("reset_ready", rdy_l, 1'b1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame from idle, LSB first
        load_word(1'b0, 4'b1101, a);
        repeat (F + 2) @(negedge clk);
        check_frames("lsb_1101", 1'b0, a, e1);

        // Back-to-back frames with valid held
        load_word(1'b0, 4'b0001, a);
        load_word(1'b0, 4'b1110, a2);
        check("b2b_no_gap", a2 - a, F);
        repeat (F + 2) @(negedge clk);
        check_frames("b2b", 1'b0, a, e2);

        // MSB first
        load_word(1'b1, 4'b1101, a);
        repeat (F + 2) @(negedge clk);
        check_frames("msb_1101", 1'b1, a, e3);

        // Loopback into a serial-in register
        @(negedge clk); sipo_clr = 1'b1;
        @(negedge clk); sipo_clr = 1'b0;
        load_word(1'b0, 4'b0000, w0);
        load_word(1'b0, 4'b1111, w1);
        load_word(1'b0, 4'b0000, w2);
        load_word(1'b0, 4'b1111, w3);
        load_word(1'b0, 4'b0000, w4);
        repeat (F + 2) @(negedge clk);
        check("loop_contig", w4 - w0, 4 * F);
        check("loop_preset", ts[w0], 4'b0101);
        check("loop_word0",  ts[w0 + F], 4'b0000);
        check("loop_word1",  ts[w0 + 2 * F], 4'b1111);
        check("loop_word2",  ts[w0 + 3 * F], 4'b0000);
        check("loop_word3",  ts[w0 + 4 * F], 4'b1111);

        // Reset mid-frame, then a fresh frame
        load_word(1'b0, 4'b1010, a);
        @(posedge clk);
        #3;
        check("mid_pre_valid", xv_l, 1'b1);
        check("mid_pre_x",     x_l,  1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_valid", xv_l,  1'b0);
        check("mid_last",  xl_l,  1'b0);
        check("mid_x",     x_l,   1'b0);
        check("mid_ready", rdy_l, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load_word(1'b0, 4'b0110, b);
        repeat (F + 2) @(negedge clk);
        check_frames("post_reset", 1'b0, b, e5);

`ifdef PISO_PARITY_EN
        // Parity bit 0 case
        load_word(1'b0, 4'b0011, a);
        repeat (F + 2) @(negedge clk);
        check_frames("par_0011", 1'b0, a, "11000");
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
